// File: rtl/simple_bus_pkg.sv
// Shared types, widths and the parity helper for the simple valid/ready bus.
// Imported by both the initiator and the reusable parity checker.
package simple_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WDATA = 3'd2,
        ST_RADDR = 3'd3,
        ST_RWAIT = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // Even parity is the plain XOR of the field; odd parity inverts it.
    function automatic logic par_calc(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/simple_bus_parity_chk.sv
// Parity compare for a received bus field, gated by an enable.
// Shared between the initiator (RDATA) and target-side checkers.
module simple_bus_parity_chk
    import simple_bus_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter bit ODD   = 1'b0
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             parity_i,
    input  logic             en_i,
    output logic             err_o
);

    assign err_o = en_i & (parity_i != ((^data_i) ^ ODD));

endmodule

// File: rtl/simple_bus_initiator.sv
// Initiator end of the simple valid/ready bus: single-beat reads and writes,
// per-channel parity generation, RDATA parity check, read timeout, sticky flags.
module simple_bus_initiator
    import simple_bus_pkg::*;
#(
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic              ACLK,
    input  logic              RESET_ACLK,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              WADDR_VALID,
    input  logic              WADDR_READY,
    output logic [ADDR_W-1:0] WADDR_DATA,
    output logic              WADDR_PARITY,
    output logic              WDATA_VALID,
    input  logic              WDATA_READY,
    output logic [DATA_W-1:0] WDATA_DATA,
    output logic              WDATA_PARITY,
    output logic              RADDR_VALID,
    input  logic              RADDR_READY,
    output logic [ADDR_W-1:0] RADDR_DATA,
    output logic              RADDR_PARITY,
    input  logic              RDATA_VALID,
    input  logic [DATA_W-1:0] RDATA_DATA,
    input  logic              RDATA_PARITY,
    output logic              RDATA_READY,
    input  logic              ENERR_RDATA_PARITY,
    input  logic              FIERR_WADDR_PARITY,
    output logic              ERR_RDATA_PARITY,
    output logic              ERR_RDATA_PARITY_B,
    output logic              ERR_TIMEOUT,
    input  logic              ERR_CLR,
    output logic [7:0]        TXN_COUNT
);

    localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [7:0]          tmo_cnt_q;
    logic [7:0]          txn_cnt_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                err_par_q;
    logic                err_tmo_q;
    logic                chk_err_s;
    logic                rd_beat_s;
    logic                par_err_s;
    logic                tmo_s;

    simple_bus_parity_chk #(
        .WIDTH (DATA_W),
        .ODD   (PARITY_ODD)
    ) u_rdata_chk (
        .data_i   (RDATA_DATA),
        .parity_i (RDATA_PARITY),
        .en_i     (ENERR_RDATA_PARITY),
        .err_o    (chk_err_s)
    );

    // RDATA only counts while we are actually waiting for it.
    assign rd_beat_s = (state_q == ST_RWAIT) & RDATA_VALID;
    assign par_err_s = rd_beat_s & chk_err_s;
    assign tmo_s     = (state_q == ST_RWAIT) & ~RDATA_VALID & (tmo_cnt_q == TMO_LAST);

    // Transaction FSM with registered response, counters and sticky error flags.
    always_ff @(posedge ACLK or posedge RESET_ACLK) begin
        if (RESET_ACLK) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            tmo_cnt_q   <= 8'd0;
            txn_cnt_q   <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_par_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (ERR_CLR) begin
                err_par_q <= 1'b0;
                err_tmo_q <= 1'b0;
            end else begin
                err_par_q <= err_par_q | par_err_s;
                err_tmo_q <= err_tmo_q | tmo_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        addr_q  <= CMD_ADDR;
                        wdata_q <= CMD_WDATA;
                        state_q <= CMD_WRITE ? ST_WADDR : ST_RADDR;
                    end
                end
                ST_WADDR: begin
                    if (WADDR_READY) begin
                        state_q <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (WDATA_READY) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                ST_RADDR: begin
                    if (RADDR_READY) begin
                        state_q   <= ST_RWAIT;
                        tmo_cnt_q <= 8'd0;
                    end
                end
                ST_RWAIT: begin
                    if (rd_beat_s) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= par_err_s;
                        rsp_rdata_q <= RDATA_DATA;
                    end else if (tmo_s) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                ST_RESP: begin
                    txn_cnt_q <= txn_cnt_q + 8'd1;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY          = (state_q == ST_IDLE);
    assign WADDR_VALID        = (state_q == ST_WADDR);
    assign WDATA_VALID        = (state_q == ST_WDATA);
    assign RADDR_VALID        = (state_q == ST_RADDR);
    assign RDATA_READY        = (state_q == ST_RWAIT);
    assign WADDR_DATA         = addr_q;
    assign RADDR_DATA         = addr_q;
    assign WDATA_DATA         = wdata_q;
    // Addresses are zero-extended, which leaves their XOR unchanged.
    assign WADDR_PARITY       = par_calc({{(DATA_W-ADDR_W){1'b0}}, addr_q}, PARITY_ODD) ^ FIERR_WADDR_PARITY;
    assign RADDR_PARITY       = par_calc({{(DATA_W-ADDR_W){1'b0}}, addr_q}, PARITY_ODD);
    assign WDATA_PARITY       = par_calc(wdata_q, PARITY_ODD);
    assign RSP_VALID          = rsp_valid_q;
    assign RSP_ERR            = rsp_err_q;
    assign RSP_RDATA          = rsp_rdata_q;
    assign ERR_RDATA_PARITY   = err_par_q;
    assign ERR_RDATA_PARITY_B = ~err_par_q;
    assign ERR_TIMEOUT        = err_tmo_q;
    assign TXN_COUNT          = txn_cnt_q;

endmodule

// File: tb/tb_simple_bus_initiator.sv
// Randomized bench for simple_bus_initiator: a reactive target with programmable
// stalls, checked against a per-transaction latency/response/flag model.
module tb_simple_bus_initiator;

    localparam bit TB_ODD = 1'b0;
    localparam int TB_TMO = 15;

    logic        ACLK = 1'b0;
    logic        RESET_ACLK;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR;
    logic [63:0] CMD_WDATA;
    logic        RSP_VALID, RSP_ERR;
    logic [63:0] RSP_RDATA;
    logic        WADDR_VALID, WADDR_READY, WADDR_PARITY;
    logic [31:0] WADDR_DATA;
    logic        WDATA_VALID, WDATA_READY, WDATA_PARITY;
    logic [63:0] WDATA_DATA;
    logic        RADDR_VALID, RADDR_READY, RADDR_PARITY;
    logic [31:0] RADDR_DATA;
    logic        RDATA_VALID, RDATA_PARITY, RDATA_READY;
    logic [63:0] RDATA_DATA;
    logic        ENERR_RDATA_PARITY, FIERR_WADDR_PARITY;
    logic        ERR_RDATA_PARITY, ERR_RDATA_PARITY_B, ERR_TIMEOUT, ERR_CLR;
    logic [7:0]  TXN_COUNT;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    bit exp_perr = 1'b0;
    bit exp_tmo = 1'b0;

    simple_bus_initiator #(.PARITY_ODD(TB_ODD), .RD_TIMEOUT(TB_TMO)) dut (
        .ACLK(ACLK), .RESET_ACLK(RESET_ACLK),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .WADDR_VALID(WADDR_VALID), .WADDR_READY(WADDR_READY),
        .WADDR_DATA(WADDR_DATA), .WADDR_PARITY(WADDR_PARITY),
        .WDATA_VALID(WDATA_VALID), .WDATA_READY(WDATA_READY),
        .WDATA_DATA(WDATA_DATA), .WDATA_PARITY(WDATA_PARITY),
        .RADDR_VALID(RADDR_VALID), .RADDR_READY(RADDR_READY),
        .RADDR_DATA(RADDR_DATA), .RADDR_PARITY(RADDR_PARITY),
        .RDATA_VALID(RDATA_VALID), .RDATA_DATA(RDATA_DATA),
        .RDATA_PARITY(RDATA_PARITY), .RDATA_READY(RDATA_READY),
        .ENERR_RDATA_PARITY(ENERR_RDATA_PARITY), .FIERR_WADDR_PARITY(FIERR_WADDR_PARITY),
        .ERR_RDATA_PARITY(ERR_RDATA_PARITY), .ERR_RDATA_PARITY_B(ERR_RDATA_PARITY_B),
        .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_CLR(ERR_CLR), .TXN_COUNT(TXN_COUNT)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_par(input logic [63:0] v);
        return (($countones(v) % 2) == 1) ^ TB_ODD;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 64'(CMD_READY), 64'd1);
        chk({tag, "_valids"}, 64'({WADDR_VALID, WDATA_VALID, RADDR_VALID, RDATA_READY}), 64'd0);
        chk({tag, "_rsp"}, 64'({RSP_VALID, RSP_ERR}), 64'd0);
        chk({tag, "_rsp_rdata"}, RSP_RDATA, 64'd0);
        chk({tag, "_data"}, 64'(WADDR_DATA) | 64'(RADDR_DATA) | WDATA_DATA, 64'd0);
        chk({tag, "_flags"}, 64'({ERR_RDATA_PARITY, ERR_RDATA_PARITY_B, ERR_TIMEOUT}), 64'b010);
        chk({tag, "_txn_count"}, 64'(TXN_COUNT), 64'd0);
    endtask

    // Called at #1 after a rising edge with the DUT idle; returns in the same phase, idle again.
    // d1 = cycles the address channel stalls; d2 = WDATA stall or RDATA delay (>= TB_TMO never answers).
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [63:0] wdat,
                           input int d1, input int d2, input logic [63:0] rdat,
                           input bit rbad, input bit en, input bit fi);
        int exp_k, c1, c2, rsp_k;
        logic [63:0] exp_rd;
        bit exp_e, tmo;
        chk("cmd_ready_idle", 64'(CMD_READY), 64'd1);
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = wdat;
        ENERR_RDATA_PARITY = en; FIERR_WADDR_PARITY = fi;
        tmo = 1'b0;
        if (wr) begin
            exp_k = 3 + d1 + d2; exp_rd = 64'd0; exp_e = 1'b0;
        end else if (d2 < TB_TMO) begin
            exp_k = 3 + d1 + d2; exp_rd = rdat; exp_e = en & rbad;
        end else begin
            exp_k = 2 + d1 + TB_TMO; exp_rd = 64'd0; exp_e = 1'b1; tmo = 1'b1;
        end
        c1 = 0; c2 = 0; rsp_k = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge ACLK); #1;
            CMD_VALID = 1'b0; CMD_WRITE = 1'($urandom); CMD_ADDR = $urandom;
            CMD_WDATA = {$urandom, $urandom};
            WADDR_READY = 1'b0; WDATA_READY = 1'b0; RADDR_READY = 1'b0;
            // Noise on RDATA outside RWAIT: bad parity that must never be flagged.
            RDATA_VALID = 1'($urandom_range(0, 1));
            RDATA_DATA = {$urandom, $urandom};
            RDATA_PARITY = ~exp_par(RDATA_DATA);
            if (WADDR_VALID) begin
                chk("waddr_data", 64'(WADDR_DATA), 64'(addr));
                chk("waddr_parity", 64'(WADDR_PARITY), 64'(exp_par(64'(addr)) ^ fi));
                WADDR_READY = (c1 == d1); c1++;
            end
            if (WDATA_VALID) begin
                chk("wdata_data", WDATA_DATA, wdat);
                chk("wdata_parity", 64'(WDATA_PARITY), 64'(exp_par(wdat)));
                WDATA_READY = (c2 == d2); c2++;
            end
            if (RADDR_VALID) begin
                chk("raddr_data", 64'(RADDR_DATA), 64'(addr));
                chk("raddr_parity", 64'(RADDR_PARITY), 64'(exp_par(64'(addr))));
                RADDR_READY = (c1 == d1); c1++;
            end
            if (RDATA_READY) begin
                RDATA_VALID = (c2 == d2); RDATA_DATA = rdat;
                RDATA_PARITY = exp_par(rdat) ^ rbad; c2++;
            end
            if (RSP_VALID) begin
                rsp_k = k;
                break;
            end
        end
        if (rsp_k == 0) begin
            chk("rsp_never_seen", 64'd0, 64'd1);
        end else begin
            chk("rsp_latency", 64'(rsp_k), 64'(exp_k));
            chk("rsp_rdata", RSP_RDATA, exp_rd);
            chk("rsp_err", 64'(RSP_ERR), 64'(exp_e));
            chk("addr_beats", 64'(c1), 64'(d1 + 1));
            chk("data_beats", 64'(c2), 64'(tmo ? TB_TMO : d2 + 1));
            exp_perr = exp_perr | (!wr && !tmo && en && rbad);
            exp_tmo  = exp_tmo | tmo;
            chk("err_rdata_parity", 64'(ERR_RDATA_PARITY), 64'(exp_perr));
            chk("err_rdata_parity_b", 64'(ERR_RDATA_PARITY_B), 64'(!exp_perr));
            chk("err_timeout", 64'(ERR_TIMEOUT), 64'(exp_tmo));
        end
        @(posedge ACLK); #1;
        FIERR_WADDR_PARITY = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        chk("rsp_one_cycle", 64'(RSP_VALID), 64'd0);
        chk("txn_count", 64'(TXN_COUNT), 64'(exp_cnt));
    endtask

    task automatic clr_pulse();
        ERR_CLR = 1'b1;
        @(posedge ACLK); #1;
        ERR_CLR = 1'b0;
        exp_perr = 1'b0; exp_tmo = 1'b0;
        chk("clr_flags", 64'({ERR_RDATA_PARITY, ERR_RDATA_PARITY_B, ERR_TIMEOUT}), 64'b010);
    endtask

    initial begin
        bit wr;
        int d2;
        RESET_ACLK = 1'b1; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
        WADDR_READY = 1'b0; WDATA_READY = 1'b0; RADDR_READY = 1'b0;
        RDATA_VALID = 1'b0; RDATA_DATA = '0; RDATA_PARITY = 1'b0;
        ENERR_RDATA_PARITY = 1'b0; FIERR_WADDR_PARITY = 1'b0; ERR_CLR = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk_reset_vals("reset");
        RESET_ACLK = 1'b0;
        @(posedge ACLK); #1;

        run_txn(1'b1, 32'h1000_0004, 64'hDEAD_BEEF_0123_4567, 0, 0, 64'd0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 32'h0000_00FF, 64'd0, 0, 0, 64'h0000_0000_0000_00FF, 1'b0, 1'b1, 1'b0);
        run_txn(1'b0, 32'h0000_00FF, 64'd0, 0, 0, 64'h0000_0000_0000_00FF, 1'b1, 1'b1, 1'b0);
        run_txn(1'b1, 32'h0000_0040, 64'h55, 1, 1, 64'd0, 1'b0, 1'b1, 1'b0);
        clr_pulse();
        run_txn(1'b0, 32'h0000_00FF, 64'd0, 0, 0, 64'h0000_0000_0000_00FF, 1'b1, 1'b0, 1'b0);
        run_txn(1'b0, 32'h0000_0080, 64'd0, 0, 255, 64'd0, 1'b0, 1'b1, 1'b0);
        run_txn(1'b0, 32'h0000_0084, 64'd0, 2, 14, 64'h1234, 1'b0, 1'b1, 1'b0);
        clr_pulse();
        run_txn(1'b1, 32'h0000_0001, 64'hA5A5, 3, 0, 64'd0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom);
            d2 = (!wr && $urandom_range(0, 4) == 0) ? int'($urandom_range(13, 16)) : int'($urandom_range(0, 3));
            run_txn(wr, $urandom, {$urandom, $urandom}, int'($urandom_range(0, 3)), d2,
                    {$urandom, $urandom}, 1'($urandom), 1'($urandom), wr & 1'($urandom));
            if ($urandom_range(0, 7) == 0) clr_pulse();
        end

        // Abort a write in WDATA with an asynchronous reset.
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 32'hFFFF_0000; CMD_WDATA = 64'hFF;
        @(posedge ACLK); #1;
        CMD_VALID = 1'b0; WADDR_READY = 1'b1;
        @(posedge ACLK); #1;
        WADDR_READY = 1'b0;
        chk("in_wdata_before_reset", 64'(WDATA_VALID), 64'd1);
        RESET_ACLK = 1'b1;
        #1;
        chk_reset_vals("midtxn_reset");
        @(posedge ACLK); #1;
        RESET_ACLK = 1'b0;
        exp_cnt = 0; exp_perr = 1'b0; exp_tmo = 1'b0;
        WDATA_READY = 1'b1;
        repeat (3) begin
            @(posedge ACLK); #1;
            chk("no_rsp_after_abort", 64'({RSP_VALID, TXN_COUNT}), 64'd0);
        end
        WDATA_READY = 1'b0;

        for (int i = 0; i < 256; i++) begin
            run_txn(1'b1, $urandom, {$urandom, $urandom}, 0, 0, 64'd0, 1'b0, 1'b0, 1'b0);
        end
        chk("txn_count_wrapped", 64'(TXN_COUNT), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
